// File: rtl/game_sequencer.sv
// Round controller for the invaders datapath: IDLE/PLAY/WIN/LOSE FSM, game-tick enable,
// debounced and rate-limited fire request, and saturating hit score. All outputs registered.
module game_sequencer #(
   parameter int TICK_DIV       = 4194304,
   parameter int DEBOUNCE_CYC   = 1000000,
   parameter int COOLDOWN_TICKS = 8,
   parameter int END_HOLD_TICKS = 64,
   parameter int SCORE_W        = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Fire_Btn,
   input  logic               Alien_Hit,
   input  logic               Aliens_Defeated,
   input  logic               Reached_Bottom,
   output logic [1:0]         Game_State,
   output logic               Game_Tick,
   output logic               Round_Clear,
   output logic               Fire_Req,
   output logic [SCORE_W-1:0] Score
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int COOL_W = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
   localparam int HOLD_W = (END_HOLD_TICKS > 1) ? $clog2(END_HOLD_TICKS) : 1;

   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
   localparam logic [COOL_W-1:0]  COOL_INIT = COOL_W'(COOLDOWN_TICKS);
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(END_HOLD_TICKS - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      WIN  = 2'b10,
      LOSE = 2'b11
   } state_t;

   state_t state;
   state_t state_nxt;

   logic              start_d;
   logic              start_rise;
   logic              enter_play;
   logic              play_stay;
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic [HOLD_W-1:0] hold_cnt;
   logic              fire_s1;
   logic              fire_s2;
   logic              deb;
   logic              deb_d;
   logic [DEB_W-1:0]  deb_cnt;
   logic [COOL_W-1:0] cooldown;
   logic              accept;

   assign start_rise = Start & ~start_d;
   assign tick       = (tick_cnt == TICK_LAST);
   assign Game_State = state;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Abort on Start low outranks both game-end flags; bottom reached outranks grid cleared.
   always_comb begin
      state_nxt  = state;
      enter_play = 1'b0;
      case (state)
         IDLE: begin
            if (start_rise) begin
               state_nxt  = PLAY;
               enter_play = 1'b1;
            end
         end
         PLAY: begin
            if (!Start) begin
               state_nxt = IDLE;
            end else if (Reached_Bottom) begin
               state_nxt = LOSE;
            end else if (Aliens_Defeated) begin
               state_nxt = WIN;
            end
         end
         WIN, LOSE: begin
            if (tick && (hold_cnt == HOLD_LAST)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      play_stay = (state == PLAY) && (state_nxt == PLAY);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         start_d <= 1'b0;
      end else begin
         start_d <= Start;
      end
   end

   // The tick counter idles at zero so every round starts on a full tick period.
   always_ff @(posedge Clk) begin
      if (Reset || (state == IDLE) || (state_nxt == IDLE)) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset || (state == IDLE) || (state == PLAY)) begin
         hold_cnt <= '0;
      end else if (tick) begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         Game_Tick   <= 1'b0;
         Round_Clear <= 1'b0;
      end else begin
         Game_Tick   <= tick && play_stay;
         Round_Clear <= enter_play;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset || enter_play) begin
         Score <= '0;
      end else if ((state == PLAY) && Alien_Hit && (Score != SCORE_MAX)) begin
         Score <= Score + 1'b1;
      end
   end

   // Button is asynchronous: two flops before anything looks at it.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         fire_s1 <= 1'b0;
         fire_s2 <= 1'b0;
         deb     <= 1'b0;
         deb_d   <= 1'b0;
         deb_cnt <= '0;
      end else begin
         fire_s1 <= Fire_Btn;
         fire_s2 <= fire_s1;
         deb_d   <= deb;
         if (fire_s2 != deb) begin
            if (deb_cnt == DEB_LAST) begin
               deb     <= ~deb;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   assign accept = deb && !deb_d && (state == PLAY) && (cooldown == '0) && !Fire_Req;

   always_ff @(posedge Clk) begin
      if (Reset || enter_play) begin
         cooldown <= '0;
      end else if (accept) begin
         cooldown <= COOL_INIT;
      end else if (tick && (cooldown != '0)) begin
         cooldown <= cooldown - 1'b1;
      end
   end

   // A request is consumed by the first Game_Tick cycle it is seen in.
   always_ff @(posedge Clk) begin
      if (Reset || !play_stay) begin
         Fire_Req <= 1'b0;
      end else if (accept) begin
         Fire_Req <= 1'b1;
      end else if (Game_Tick) begin
         Fire_Req <= 1'b0;
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small parameters; every edge is numbered from the
// round-start edge E0 and outputs are sampled 1 time unit after each rising edge.
module tb_game_sequencer;

   logic       Clk;
   logic       Reset;
   logic       Start;
   logic       Fire_Btn;
   logic       Alien_Hit;
   logic       Aliens_Defeated;
   logic       Reached_Bottom;
   logic [1:0] Game_State;
   logic       Game_Tick;
   logic       Round_Clear;
   logic       Fire_Req;
   logic [3:0] Score;

   int vecs = 0;
   int errs = 0;

   game_sequencer #(
      .TICK_DIV(4),
      .DEBOUNCE_CYC(3),
      .COOLDOWN_TICKS(2),
      .END_HOLD_TICKS(3),
      .SCORE_W(4)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .Start(Start),
      .Fire_Btn(Fire_Btn),
      .Alien_Hit(Alien_Hit),
      .Aliens_Defeated(Aliens_Defeated),
      .Reached_Bottom(Reached_Bottom),
      .Game_State(Game_State),
      .Game_Tick(Game_Tick),
      .Round_Clear(Round_Clear),
      .Fire_Req(Fire_Req),
      .Score(Score)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Leaves the bench just after E0, the edge that entered PLAY.
   task automatic begin_round();
      Reset = 1'b1; Start = 1'b0; Fire_Btn = 1'b0; Alien_Hit = 1'b0;
      Aliens_Defeated = 1'b0; Reached_Bottom = 1'b0;
      step(); step();
      Reset = 1'b0;
      step();
      Start = 1'b1;
      step();
   endtask

   task automatic test_reset();
      Reset = 1'b1; Start = 1'b0; Fire_Btn = 1'b0; Alien_Hit = 1'b0;
      Aliens_Defeated = 1'b0; Reached_Bottom = 1'b0;
      step(); step();
      vecs++; if (Game_State !== 2'b00) begin errs++; $display("FAIL reset_state: got %0d want 0", Game_State); end
      vecs++; if (Game_Tick !== 1'b0) begin errs++; $display("FAIL reset_tick: got %b want 0", Game_Tick); end
      vecs++; if (Round_Clear !== 1'b0) begin errs++; $display("FAIL reset_clear: got %b want 0", Round_Clear); end
      vecs++; if (Fire_Req !== 1'b0) begin errs++; $display("FAIL reset_fire: got %b want 0", Fire_Req); end
      vecs++; if (Score !== 4'd0) begin errs++; $display("FAIL reset_score: got %0d want 0", Score); end
      Reset = 1'b0;
      step();
      vecs++; if (Game_State !== 2'b00) begin errs++; $display("FAIL reset_idle: got %0d want 0", Game_State); end
   endtask

   task automatic test_start();
      begin_round();
      vecs++; if (Round_Clear !== 1'b1) begin errs++; $display("FAIL start_clear: got %b want 1", Round_Clear); end
      vecs++; if (Game_State !== 2'b01) begin errs++; $display("FAIL start_state: got %0d want 1", Game_State); end
      vecs++; if (Game_Tick !== 1'b0) begin errs++; $display("FAIL start_tick0: got %b want 0", Game_Tick); end
      for (int k = 1; k <= 12; k++) begin
         step();
         vecs++; if (Game_Tick !== ((k % 4) == 0)) begin errs++; $display("FAIL start_tick E%0d: got %b want %b", k, Game_Tick, (k % 4) == 0); end
         vecs++; if (Round_Clear !== 1'b0) begin errs++; $display("FAIL start_clear_pulse E%0d: got %b want 0", k, Round_Clear); end
         if (k == 12) Aliens_Defeated = 1'b1;
      end
      for (int k = 13; k <= 24; k++) begin
         step();
         vecs++; if (Game_State !== ((k < 24) ? 2'b10 : 2'b00)) begin errs++; $display("FAIL win_hold E%0d: got %0d want %0d", k, Game_State, (k < 24) ? 2 : 0); end
         vecs++; if (Game_Tick !== 1'b0) begin errs++; $display("FAIL win_tick E%0d: got %b want 0", k, Game_Tick); end
      end
      Aliens_Defeated = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         vecs++; if (Game_State !== 2'b00) begin errs++; $display("FAIL held_start_restart: got %0d want 0", Game_State); end
      end
      Start = 1'b0;
      step();
      Start = 1'b1;
      step();
      vecs++; if (Game_State !== 2'b01) begin errs++; $display("FAIL fresh_start: got %0d want 1", Game_State); end
      vecs++; if (Round_Clear !== 1'b1) begin errs++; $display("FAIL fresh_clear: got %b want 1", Round_Clear); end
   endtask

   task automatic test_fire();
      begin_round();
      Fire_Btn = 1'b1;
      for (int k = 1; k <= 28; k++) begin
         step();
         vecs++; if (Fire_Req !== (k >= 6 && k <= 8)) begin errs++; $display("FAIL fire_req E%0d: got %b want %b", k, Fire_Req, (k >= 6 && k <= 8)); end
         vecs++; if (Game_Tick !== ((k % 4) == 0)) begin errs++; $display("FAIL fire_tick E%0d: got %b want %b", k, Game_Tick, (k % 4) == 0); end
         if (k == 9)  Fire_Btn = 1'b0;
         if (k == 15) Fire_Btn = 1'b1;
         if (k == 17) Fire_Btn = 1'b0;
      end
   endtask

   task automatic test_cooldown();
      begin_round();
      Fire_Btn = 1'b1;
      for (int k = 1; k <= 26; k++) begin
         step();
         vecs++; if (Fire_Req !== ((k >= 6 && k <= 8) || (k >= 21 && k <= 24))) begin
            errs++; $display("FAIL cooldown_req E%0d: got %b want %b", k, Fire_Req, ((k >= 6 && k <= 8) || (k >= 21 && k <= 24)));
         end
         if (k == 3)  Fire_Btn = 1'b0;
         if (k == 6)  Fire_Btn = 1'b1;
         if (k == 9)  Fire_Btn = 1'b0;
         if (k == 15) Fire_Btn = 1'b1;
         if (k == 18) Fire_Btn = 1'b0;
      end
   endtask

   task automatic test_score();
      begin_round();
      Alien_Hit = 1'b1;
      step(); step(); step();
      Alien_Hit = 1'b0;
      vecs++; if (Score !== 4'd3) begin errs++; $display("FAIL score_three: got %0d want 3", Score); end
      Start = 1'b0;
      step();
      vecs++; if (Game_State !== 2'b00) begin errs++; $display("FAIL abort_state: got %0d want 0", Game_State); end
      vecs++; if (Score !== 4'd3) begin errs++; $display("FAIL abort_score: got %0d want 3", Score); end
      Alien_Hit = 1'b1;
      step(); step();
      Alien_Hit = 1'b0;
      vecs++; if (Score !== 4'd3) begin errs++; $display("FAIL idle_hit: got %0d want 3", Score); end
      Start = 1'b1;
      step();
      vecs++; if (Score !== 4'd0) begin errs++; $display("FAIL score_clear: got %0d want 0", Score); end
      Alien_Hit = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         step();
         vecs++; if (Score !== ((i < 15) ? i : 15)) begin errs++; $display("FAIL score_sat hit%0d: got %0d want %0d", i, Score, (i < 15) ? i : 15); end
      end
      Alien_Hit = 1'b0;
   endtask

   task automatic test_end();
      begin_round();
      Alien_Hit = 1'b1;
      step();
      vecs++; if (Score !== 4'd1) begin errs++; $display("FAIL end_score1: got %0d want 1", Score); end
      Aliens_Defeated = 1'b1;
      Reached_Bottom = 1'b1;
      step();
      Alien_Hit = 1'b0;
      vecs++; if (Game_State !== 2'b11) begin errs++; $display("FAIL both_flags_lose: got %0d want 3", Game_State); end
      vecs++; if (Score !== 4'd2) begin errs++; $display("FAIL exit_edge_hit: got %0d want 2", Score); end
      for (int k = 3; k <= 12; k++) begin
         step();
         vecs++; if (Game_State !== ((k < 12) ? 2'b11 : 2'b00)) begin errs++; $display("FAIL lose_hold E%0d: got %0d want %0d", k, Game_State, (k < 12) ? 3 : 0); end
         vecs++; if (Score !== 4'd2) begin errs++; $display("FAIL lose_score E%0d: got %0d want 2", k, Score); end
         vecs++; if (Game_Tick !== 1'b0) begin errs++; $display("FAIL lose_tick E%0d: got %b want 0", k, Game_Tick); end
         if (k == 5) Start = 1'b0;
         if (k == 6) Alien_Hit = 1'b1;
         if (k == 7) Alien_Hit = 1'b0;
      end
      Aliens_Defeated = 1'b0;
      Reached_Bottom = 1'b0;
      begin_round();
      Start = 1'b0;
      Reached_Bottom = 1'b1;
      step();
      vecs++; if (Game_State !== 2'b00) begin errs++; $display("FAIL abort_priority: got %0d want 0", Game_State); end
      Reached_Bottom = 1'b0;
   endtask

   task automatic test_reset_mid();
      begin_round();
      Fire_Btn = 1'b1;
      Alien_Hit = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 1) Alien_Hit = 1'b0;
      end
      vecs++; if (Fire_Req !== 1'b1) begin errs++; $display("FAIL mid_pre_fire: got %b want 1", Fire_Req); end
      vecs++; if (Score !== 4'd1) begin errs++; $display("FAIL mid_pre_score: got %0d want 1", Score); end
      Reset = 1'b1;
      step();
      vecs++; if (Game_State !== 2'b00) begin errs++; $display("FAIL mid_state: got %0d want 0", Game_State); end
      vecs++; if (Fire_Req !== 1'b0) begin errs++; $display("FAIL mid_fire: got %b want 0", Fire_Req); end
      vecs++; if (Score !== 4'd0) begin errs++; $display("FAIL mid_score: got %0d want 0", Score); end
      vecs++; if (Game_Tick !== 1'b0) begin errs++; $display("FAIL mid_tick: got %b want 0", Game_Tick); end
      Reset = 1'b0;
      Fire_Btn = 1'b0;
      step();
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Fire_Btn = 1'b0; Alien_Hit = 1'b0;
      Aliens_Defeated = 1'b0; Reached_Bottom = 1'b0;
      test_reset();
      test_start();
      test_fire();
      test_cooldown();
      test_score();
      test_end();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
